// File: rtl/arb_mux_if.sv
// arb_mux_if: channel-side and output-side handshake bundle for arb_mux.
interface arb_mux_if #(
    parameter int WIDTH = 16,
    parameter int NCH   = 8,
    parameter int SELW  = 3
);
    logic                   mode;
    logic [SELW-1:0]        sel;
    logic [NCH*WIDTH-1:0]   in_data;
    logic [NCH-1:0]         in_valid;
    logic [NCH-1:0]         in_ready;
    logic [WIDTH-1:0]       out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [SELW-1:0]        out_ch;
    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_ch
    );
    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_ch
    );
endinterface

// File: rtl/arb_mux.sv
// arb_mux: N-channel arbiter (direct select or round-robin) feeding a one-word output register.
module arb_mux #(
    parameter int WIDTH = 16,
    parameter int NCH   = 8,
    parameter int SELW  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    arb_mux_if.slave   bus
);
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  out_ch_q, out_ch_d;
    logic [SELW-1:0]  ptr_q, ptr_d;
    logic [SELW-1:0]  gnt, cand;
    logic             gnt_vld, load_en;

    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        cand    = '0;
        if (!bus.mode) begin
            gnt = bus.sel;
            for (int k = 0; k < NCH; k++)
                if (bus.sel == SELW'(k) && bus.in_valid[k]) gnt_vld = 1'b1;
        end else begin
            // descending offsets so the channel nearest ptr is written last and wins
            for (int j = NCH - 1; j >= 0; j--) begin
                cand = SELW'((int'(ptr_q) + j) % NCH);
                if (bus.in_valid[cand]) begin
                    gnt     = cand;
                    gnt_vld = 1'b1;
                end
            end
        end
    end

    assign load_en = !out_valid_q || bus.out_ready;

    always_comb begin
        bus.in_ready = '0;
        for (int k = 0; k < NCH; k++)
            bus.in_ready[k] = rst_n && load_en && gnt_vld && gnt == SELW'(k);
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
        if (load_en) begin
            out_valid_d = gnt_vld;
            if (gnt_vld) begin
                out_data_d = bus.in_data[gnt*WIDTH +: WIDTH];
                out_ch_d   = gnt;
                if (bus.mode) ptr_d = (gnt == SELW'(NCH - 1)) ? '0 : gnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_ch    = out_ch_q;
endmodule

// File: tb/tb_arb_mux.sv
// tb_arb_mux: directed-vector bench for arb_mux with immediate-assertion checks.
module tb_arb_mux;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    logic [15:0] vals [8] = '{16'd5, 16'd29, 16'd38, 16'd51, 16'd64, 16'd82, 16'd94, 16'd112};

    always #5 clk = ~clk;

    arb_mux_if #(.WIDTH(16), .NCH(8), .SELW(3)) bus ();
    arb_mux #(.WIDTH(16), .NCH(8), .SELW(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [15:0] d, input logic [2:0] c);
        check({tag, ".valid"}, {31'd0, bus.out_valid}, {31'd0, v});
        check({tag, ".data"}, {16'd0, bus.out_data}, {16'd0, d});
        check({tag, ".ch"}, {29'd0, bus.out_ch}, {29'd0, c});
    endtask

    task automatic check_rdy(input string tag, input logic [7:0] exp);
        check({tag, ".in_ready"}, {24'd0, bus.in_ready}, {24'd0, exp});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] rr_exp [4] = '{3'd2, 3'd5, 3'd2, 3'd5};
        bus.mode      = 1'b0;
        bus.sel       = '0;
        bus.in_valid  = '1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) bus.in_data[k*16 +: 16] = vals[k];

        // reset state: in_ready must stay low even though sel=0 is valid
        #12;
        check_out("reset", 1'b0, 16'd0, 3'd0);
        check_rdy("reset", 8'h00);
        rst_n = 1'b1;

        // direct select sweep
        for (int s = 0; s < 8; s++) begin
            bus.sel = 3'(s);
            #1;
            check_rdy($sformatf("sweep%0d", s), 8'(1 << s));
            tick();
            check_out($sformatf("sweep%0d", s), 1'b1, vals[s], 3'(s));
        end

        // round-robin, all valid, ptr still 0 after mode 0 traffic
        bus.mode = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            check_rdy($sformatf("rr_all%0d", i), 8'(1 << (i % 8)));
            tick();
            check_out($sformatf("rr_all%0d", i), 1'b1, vals[i % 8], 3'(i % 8));
        end

        // round-robin, only ch2 and ch5 valid; ptr starts at 2
        bus.in_valid = 8'b0010_0100;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_rdy($sformatf("rr_sparse%0d", i), 8'(1 << rr_exp[i]));
            tick();
            check_out($sformatf("rr_sparse%0d", i), 1'b1, vals[rr_exp[i]], rr_exp[i]);
        end

        // backpressure: hold 38 for three cycles while sel moves to 4
        bus.mode     = 1'b0;
        bus.in_valid = '1;
        bus.sel      = 3'd2;
        tick();
        check_out("load38", 1'b1, 16'd38, 3'd2);
        bus.out_ready = 1'b0;
        bus.sel       = 3'd4;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_rdy($sformatf("stall%0d", i), 8'h00);
            tick();
            check_out($sformatf("stall%0d", i), 1'b1, 16'd38, 3'd2);
        end
        bus.out_ready = 1'b1;
        #1;
        check_rdy("release", 8'h10);
        tick();
        check_out("release", 1'b1, 16'd64, 3'd4);

        // direct select of an invalid channel drains the register, data holds
        bus.sel      = 3'd3;
        bus.in_valid = 8'b1111_0111;
        #1;
        check_rdy("nogrant", 8'h00);
        tick();
        check_out("nogrant", 1'b0, 16'd64, 3'd4);

        // round-robin from ptr=6 (left by ch5), then async reset mid-cycle
        bus.mode     = 1'b1;
        bus.in_valid = '1;
        #1;
        check_rdy("pre_rst", 8'h40);
        tick();
        check_out("pre_rst", 1'b1, 16'd94, 3'd6);
        bus.out_ready = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check_out("async_rst", 1'b0, 16'd0, 3'd0);
        check_rdy("async_rst", 8'h00);
        tick();
        check_out("rst_held", 1'b0, 16'd0, 3'd0);
        rst_n         = 1'b1;
        bus.in_valid  = 8'b1010_0000;
        bus.out_ready = 1'b1;
        #1;
        check_rdy("post_rst", 8'h20);
        tick();
        check_out("post_rst", 1'b1, 16'd82, 3'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/arb_mux.md
ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, data width per channel.
REQ-002 The block SHALL have parameter NCH, default 8, number of input channels (2..16).
REQ-003 The block SHALL have parameter SELW, default 3, select/channel-index width, equal to ceil(log2(NCH)).
REQ-004 The block SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 The block SHALL have port mode  input  1  grant policy: 0 = direct select, 1 = round-robin.
REQ-007 The block SHALL have port sel  input  SELW  channel index used when mode=0.
REQ-008 The block SHALL have port in_data  input  NCH*WIDTH  packed channel data; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-009 The block SHALL have port in_valid  input  NCH  per-channel data-valid.
REQ-010 The block SHALL have port in_ready  output  NCH  per-channel accept strobe, combinational.
REQ-011 The block SHALL have port out_data  output  WIDTH  registered selected data.
REQ-012 The block SHALL have port out_valid  output  1  out_data holds an unconsumed word.
REQ-013 The block SHALL have port out_ready  input  1  downstream accepts out_data this cycle.
REQ-014 The block SHALL have port out_ch  output  SELW  index of the channel that supplied out_data.

Function
REQ-015 The block SHALL hold one output word in a register; load_en = !out_valid || out_ready.
REQ-016 In mode=0, the granted channel SHALL be sel, provided sel < NCH and in_valid[sel]=1; otherwise no grant.
REQ-017 In mode=1, the granted channel SHALL be the first k with in_valid[k]=1, searching ptr, ptr+1, ... modulo NCH.
REQ-018 At most one in_ready bit SHALL be 1: in_ready[g]=1 iff load_en and g is granted; in_ready SHALL not depend on in_ready.
REQ-019 On a clock edge with load_en and a grant g, out_data SHALL take in_data channel g, out_ch SHALL take g, out_valid SHALL become 1.
REQ-020 On a clock edge with load_en and no grant, out_valid SHALL become 0; out_data and out_ch SHALL hold.
REQ-021 With out_valid=1 and out_ready=0, out_data, out_ch and out_valid SHALL hold and all in_ready SHALL be 0.
REQ-022 Latency SHALL be one cycle input-to-output; sustained throughput SHALL be one word per cycle when out_ready=1.
REQ-023 ptr SHALL update to g+1 only on a mode=1 transfer; g=NCH-1 SHALL wrap ptr to 0.
REQ-024 ptr SHALL hold in mode=0 and on cycles without a transfer.
REQ-025 A mode or sel change SHALL take effect on the same cycle's grant; it SHALL not alter an already-registered word.

Reset
REQ-026 While rst_n=0, out_valid SHALL be 0, out_data 0, out_ch 0, ptr 0, and all in_ready 0, independent of clk.
REQ-027 Reset asserted mid-transfer SHALL discard the held word; the first grant after release SHALL start searching from channel 0.

Verification
REQ-028 mode=0, in_data = {112,94,82,64,51,38,29,5} (ch7..ch0), all valid, out_ready=1, sel sweeps 0..7 one per cycle -> out_data 5,29,38,51,64,82,94,112 with out_ch 0..7, each one cycle after its sel.
REQ-029 mode=1, all eight valid, out_ready=1 for 10 cycles -> out_ch 0,1,..,7,0,1; ptr wraps after ch7.
REQ-030 mode=1, only ch2 and ch5 valid -> out_ch alternates 2,5,2,5; in_ready never set for other channels.
REQ-031 out_valid=1 with out_data=38, out_ready held 0 for 3 cycles -> out_data stays 38, in_ready=0; release -> next word loads on following edge.
REQ-032 mode=0, sel=3, in_valid[3]=0 -> no in_ready, out_valid falls to 0 once drained, out_data holds.
REQ-033 rst_n pulled low between edges while out_valid=1 -> out_valid, out_data, out_ch go 0 immediately; mode=1 after release grants lowest-index valid channel.
